fp_div_dispatcher: RTL and testbench
====================================

Name: fp_div_dispatcher

Overview:
- Initiator side of the sequential FP divider handshake (En/OpA/OpB/Tag/Rnd out; Valid/Res/Status/Tag/Ready in).
- Arbitrates divide requests from NUM_REQ cores round-robin, issues one at a time, and tags each op with the requester index.
- The divider result cannot be stalled, so the block buffers results in a small response FIFO and routes each one back to its requester with a valid/ready handshake.
- Sits between the core-side APU interconnect ports and the shared divider instance.

Parameters:
- NUM_REQ, 4, number of requesting cores (>=2).
- ID_WIDTH, $clog2(NUM_REQ), requester-index width; also the divider tag width.
- FP_WIDTH, 32, operand/result width.
- RND_WIDTH, 3, rounding-mode width.
- STAT_WIDTH, 5, divider status-flag width.
- RESP_DEPTH, 2, response FIFO depth (>=1); also the issue credit limit.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- req_i  in  NUM_REQ  per-core divide request
- gnt_o  out  NUM_REQ  per-core grant; op accepted when req_i[i]&gnt_o[i]
- op_a_i  in  NUM_REQ*FP_WIDTH  dividends, slice i for core i
- op_b_i  in  NUM_REQ*FP_WIDTH  divisors
- rnd_i  in  NUM_REQ*RND_WIDTH  rounding modes
- resp_valid_o  out  NUM_REQ  result available for core i
- resp_ready_i  in  NUM_REQ  core i accepts result
- resp_res_o  out  FP_WIDTH  result, broadcast to all cores
- resp_status_o  out  STAT_WIDTH  status flags, broadcast
- div_en_o  out  1  issue strobe to divider
- div_op_a_o / div_op_b_o  out  FP_WIDTH  operands to divider
- div_rnd_o  out  RND_WIDTH  rounding mode to divider
- div_tag_o  out  ID_WIDTH  requester index to divider
- div_ready_i  in  1  divider can accept an op this cycle
- div_valid_i  in  1  one-cycle result pulse from divider
- div_res_i  in  FP_WIDTH  divider result
- div_status_i  in  STAT_WIDTH  divider status
- div_tag_i  in  ID_WIDTH  returned tag
- err_o  out  1  sticky protocol-error flag

Behaviour:
- Reset: gnt_o=0, resp_valid_o=0, div_en_o=0, err_o=0; FIFO empty; credit counter=0; RR pointer=0. Reset mid-operation discards all in-flight ops; the divider shares rst_ni.
- Credits: credit_cnt = ops issued but not yet popped from the FIFO; 0..RESP_DEPTH.
  - Issue is allowed iff credit_cnt < RESP_DEPTH and div_ready_i.
  - +1 on issue, -1 on FIFO pop, unchanged when both happen in one cycle.
- Arbitration (combinational grant, registered pointer):
  - Winner = first asserted req_i at or after ptr, wrapping NUM_REQ-1 -> 0.
  - gnt_o is one-hot to the winner when issue is allowed, else 0.
  - div_en_o = |req_i & issue allowed; div_op_*/div_rnd_o/div_tag_o = the winner's slice.
  - On issue, ptr <= winner+1 mod NUM_REQ; otherwise ptr holds.
- Latency: the request is granted in the cycle it is presented if a credit and div_ready_i are available.
- Capture: on div_valid_i, push {div_tag_i, div_res_i, div_status_i} into the FIFO (circular, wrap at RESP_DEPTH).
- Response:
  - FIFO head drives resp_res_o/resp_status_o.
  - resp_valid_o = onehot(head tag) when the FIFO is non-empty, else 0.
  - Pop when resp_ready_i[head tag] is high. Simultaneous push and pop are allowed at any occupancy, including full.
- Ordering: results return in divider completion order; no per-core reordering.
- Errors (set err_o, sticky until reset):
  - div_valid_i while credit_cnt==0: result dropped.
  - div_valid_i while the FIFO is full with no pop: result dropped, FIFO unchanged.
- Outputs are stable while resp_valid_o is high and not popped.

Optional Feature:
- FP_DIV_DISP_BYPASS_EN defined: when the FIFO is empty, div_valid_i is high and resp_ready_i[div_tag_i] is high, the result is presented directly on resp_* in the same cycle. It is not pushed, and credit_cnt decrements that cycle. Zero-cycle return latency.
- Undefined: every result goes through the FIFO; minimum 1 cycle from div_valid_i to resp_valid_o.

Decomposition:
- apu_cluster_package: FP_WIDTH, RND_WIDTH, STAT_WIDTH defaults and typedef div_resp_t {tag, res, status}.
- One sub-module, fp_div_resp_fifo: parameterised depth, push/pop, full/empty, head output. The arbiter and credit logic stay in the top.

Test Plan:
- Single op: req_i=0001, A=0x40400000, B=0x3F800000, div_ready_i=1 -> gnt_o=0001 same cycle, div_tag_o=0; model returns 0x40400000 tag 0 -> resp_valid_o=0001 one cycle later (zero cycles with bypass).
- Round-robin: req_i=1111 held, ready every cycle -> grant order 0,1,2,3,0; ptr wraps 3->0.
- Credit stall: RESP_DEPTH=2, resp_ready_i=0, two ops completed -> gnt_o=0 until a pop; one pop -> one new grant.
- Backpressure with simultaneous push/pop: FIFO full, pop and div_valid_i in the same cycle -> occupancy stays 2, no err_o, order preserved.
- Spurious result: div_valid_i pulse with nothing in flight -> err_o=1, resp_valid_o stays 0, err_o held until rst_ni.
- Reset mid-op: assert rst_ni low with 2 results buffered -> all outputs 0, credit_cnt=0; after release a new op is granted immediately.

Source files
------------

// File: rtl/fp_div_dispatcher_pkg.sv
// Shared widths and the divider response record for the APU divider dispatch slice.
package apu_cluster_package;

   localparam int unsigned DEF_NUM_REQ    = 4;
   localparam int unsigned DEF_ID_WIDTH   = $clog2(DEF_NUM_REQ);
   localparam int unsigned DEF_FP_WIDTH   = 32;
   localparam int unsigned DEF_RND_WIDTH  = 3;
   localparam int unsigned DEF_STAT_WIDTH = 5;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]   tag;
      logic [DEF_FP_WIDTH-1:0]   res;
      logic [DEF_STAT_WIDTH-1:0] status;
   } div_resp_t;

endpackage

// File: rtl/fp_div_dispatcher_resp_fifo.sv
// Circular response buffer for divider results; caller guarantees push is legal and pop only when non-empty.
module fp_div_resp_fifo
   import apu_cluster_package::*;
#(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned WIDTH = DEF_ID_WIDTH + DEF_FP_WIDTH + DEF_STAT_WIDTH
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_q] <= data_i;
            wr_q        <= inc(wr_q);
         end
         if (pop_i) rd_q <= inc(rd_q);
         if (push_i && !pop_i)      cnt_q <= cnt_q + CW'(1);
         else if (!push_i && pop_i) cnt_q <= cnt_q - CW'(1);
      end
   end

   assign data_o  = mem_q[rd_q];
   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CW'(DEPTH));

endmodule

// File: rtl/fp_div_dispatcher.sv
// Round-robin, credit-limited dispatcher for a shared FP divider with buffered, tag-routed results.
// Optional zero-latency return path when FP_DIV_DISP_BYPASS_EN is defined.
module fp_div_dispatcher
   import apu_cluster_package::*;
#(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ),
   parameter int unsigned FP_WIDTH   = DEF_FP_WIDTH,
   parameter int unsigned RND_WIDTH  = DEF_RND_WIDTH,
   parameter int unsigned STAT_WIDTH = DEF_STAT_WIDTH,
   parameter int unsigned RESP_DEPTH = 2
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   input  logic [NUM_REQ-1:0]              req_i,
   output logic [NUM_REQ-1:0]              gnt_o,
   input  logic [NUM_REQ*FP_WIDTH-1:0]     op_a_i,
   input  logic [NUM_REQ*FP_WIDTH-1:0]     op_b_i,
   input  logic [NUM_REQ*RND_WIDTH-1:0]    rnd_i,
   output logic [NUM_REQ-1:0]              resp_valid_o,
   input  logic [NUM_REQ-1:0]              resp_ready_i,
   output logic [FP_WIDTH-1:0]             resp_res_o,
   output logic [STAT_WIDTH-1:0]           resp_status_o,
   output logic                            div_en_o,
   output logic [FP_WIDTH-1:0]             div_op_a_o,
   output logic [FP_WIDTH-1:0]             div_op_b_o,
   output logic [RND_WIDTH-1:0]            div_rnd_o,
   output logic [ID_WIDTH-1:0]             div_tag_o,
   input  logic                            div_ready_i,
   input  logic                            div_valid_i,
   input  logic [FP_WIDTH-1:0]             div_res_i,
   input  logic [STAT_WIDTH-1:0]           div_status_i,
   input  logic [ID_WIDTH-1:0]             div_tag_i,
   output logic                            err_o
);

   localparam int unsigned CW = $clog2(RESP_DEPTH + 1);
   localparam int unsigned EW = ID_WIDTH + FP_WIDTH + STAT_WIDTH;

   logic [ID_WIDTH-1:0]   ptr_q, winner;
   int unsigned           win_idx, scan_idx;
   logic                  found, issue;
   logic [CW-1:0]         credit_q;
   logic                  err_q;
   logic                  fifo_empty, fifo_full, push, pop, bypass, head_rdy, dec;
   logic [EW-1:0]         fifo_dout;
   logic [ID_WIDTH-1:0]   head_tag;
   logic [FP_WIDTH-1:0]   head_res;
   logic [STAT_WIDTH-1:0] head_status;

   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         scan_idx = 32'(ptr_q) + k;
         if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
         if (!found && req_i[scan_idx]) begin
            winner = ID_WIDTH'(scan_idx);
            found  = 1'b1;
         end
      end
   end

   assign win_idx = 32'(winner);
   assign issue   = found && div_ready_i && (credit_q < CW'(RESP_DEPTH));

   always_comb begin
      gnt_o = '0;
      if (issue) gnt_o[win_idx] = 1'b1;
   end

   assign div_en_o   = issue;
   assign div_op_a_o = op_a_i[win_idx*FP_WIDTH +: FP_WIDTH];
   assign div_op_b_o = op_b_i[win_idx*FP_WIDTH +: FP_WIDTH];
   assign div_rnd_o  = rnd_i[win_idx*RND_WIDTH +: RND_WIDTH];
   assign div_tag_o  = winner;

   assign {head_tag, head_res, head_status} = fifo_dout;

   always_comb begin
      head_rdy = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (head_tag == ID_WIDTH'(i)) head_rdy = resp_ready_i[i];
   end

`ifdef FP_DIV_DISP_BYPASS_EN
   logic dtag_rdy;
   always_comb begin
      dtag_rdy = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         if (div_tag_i == ID_WIDTH'(i)) dtag_rdy = resp_ready_i[i];
   end
   assign bypass = fifo_empty && div_valid_i && (credit_q != '0) && dtag_rdy;
`else
   assign bypass = 1'b0;
`endif

   assign pop  = !fifo_empty && head_rdy;
   assign push = div_valid_i && (credit_q != '0) && (!fifo_full || pop) && !bypass;
   assign dec  = pop || bypass;

   always_comb begin
      resp_valid_o = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++)
         resp_valid_o[i] = (!fifo_empty && head_tag == ID_WIDTH'(i)) ||
                           (bypass && div_tag_i == ID_WIDTH'(i));
   end

   assign resp_res_o    = bypass ? div_res_i    : head_res;
   assign resp_status_o = bypass ? div_status_i : head_status;
   assign err_o         = err_q;

   // Credit decrement saturates: a push+pop at full can leave more entries than credits.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q    <= '0;
         credit_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (issue) ptr_q <= (win_idx == NUM_REQ - 1) ? '0 : winner + ID_WIDTH'(1);
         if (issue && !dec)                        credit_q <= credit_q + CW'(1);
         else if (!issue && dec && credit_q != '0) credit_q <= credit_q - CW'(1);
         if (div_valid_i && (credit_q == '0 || (fifo_full && !pop))) err_q <= 1'b1;
      end
   end

   fp_div_resp_fifo #(
      .DEPTH (RESP_DEPTH),
      .WIDTH (EW)
   ) u_resp_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (push),
      .data_i  ({div_tag_i, div_res_i, div_status_i}),
      .pop_i   (pop),
      .data_o  (fifo_dout),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

endmodule

// File: tb/tb_fp_div_dispatcher.sv
// Directed scoreboard bench: stimulus pushes expected results, a negedge monitor pops on each handshake.
module tb_fp_div_dispatcher;
   import apu_cluster_package::*;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic [3:0]    req_i, gnt_o, resp_valid_o, resp_ready_i;
   logic [127:0]  op_a_i, op_b_i;
   logic [11:0]   rnd_i;
   logic [31:0]   resp_res_o, div_op_a_o, div_op_b_o, div_res_i;
   logic [4:0]    resp_status_o, div_status_i;
   logic          div_en_o, div_ready_i, div_valid_i, err_o;
   logic [2:0]    div_rnd_o;
   logic [1:0]    div_tag_o, div_tag_i;

   int unsigned   checks = 0;
   int unsigned   errors = 0;
   div_resp_t     exp_q[$];
   div_resp_t     mon_e;

   always #5 clk_i = ~clk_i;

   fp_div_dispatcher #(
      .NUM_REQ    (4),
      .RESP_DEPTH (2)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_i         (req_i),
      .gnt_o         (gnt_o),
      .op_a_i        (op_a_i),
      .op_b_i        (op_b_i),
      .rnd_i         (rnd_i),
      .resp_valid_o  (resp_valid_o),
      .resp_ready_i  (resp_ready_i),
      .resp_res_o    (resp_res_o),
      .resp_status_o (resp_status_o),
      .div_en_o      (div_en_o),
      .div_op_a_o    (div_op_a_o),
      .div_op_b_o    (div_op_b_o),
      .div_rnd_o     (div_rnd_o),
      .div_tag_o     (div_tag_o),
      .div_ready_i   (div_ready_i),
      .div_valid_i   (div_valid_i),
      .div_res_i     (div_res_i),
      .div_status_i  (div_status_i),
      .div_tag_i     (div_tag_i),
      .err_o         (err_o)
   );

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   always @(negedge clk_i) begin
      if (rst_ni) begin
         for (int i = 0; i < 4; i++) begin
            if (resp_valid_o[i] && resp_ready_i[i]) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL resp_unexpected: got result %h for core %0d expected none", resp_res_o, i);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("resp_tag", 64'(i), 64'(mon_e.tag));
                  chk("resp_res", 64'(resp_res_o), 64'(mon_e.res));
                  chk("resp_status", 64'(resp_status_o), 64'(mon_e.status));
               end
            end
         end
      end
   end

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] r);
      op_a_i[i*32 +: 32] = a;
      op_b_i[i*32 +: 32] = b;
      rnd_i[i*3 +: 3]    = r;
   endtask

   task automatic div_ret(input logic [1:0] tag, input logic [31:0] res, input logic [4:0] st, input bit expect_it);
      div_resp_t e;
      div_valid_i  = 1'b1;
      div_tag_i    = tag;
      div_res_i    = res;
      div_status_i = st;
      if (expect_it) begin
         e.tag = tag; e.res = res; e.status = st;
         exp_q.push_back(e);
      end
      step();
      div_valid_i = 1'b0;
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      exp_q.delete();
      req_i  = '0;
      div_valid_i = 1'b0;
      step();
      step();
      rst_ni = 1'b1;
   endtask

   logic [1:0] rr_ord [5];

   initial begin
      rr_ord = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      rst_ni = 1'b0;
      req_i = '0; resp_ready_i = '0; op_a_i = '0; op_b_i = '0; rnd_i = '0;
      div_ready_i = 1'b1; div_valid_i = 1'b0; div_res_i = '0; div_status_i = '0; div_tag_i = '0;
      step();
      step();
      chk("rst_gnt", 64'(gnt_o), 64'h0);
      chk("rst_valid", 64'(resp_valid_o), 64'h0);
      chk("rst_en", 64'(div_en_o), 64'h0);
      chk("rst_err", 64'(err_o), 64'h0);
      rst_ni = 1'b1;

      // single op
      resp_ready_i = '1;
      set_op(0, 32'h4040_0000, 32'h3F80_0000, 3'd1);
      req_i = 4'b0001;
      #1;
      chk("single_gnt", 64'(gnt_o), 64'h1);
      chk("single_en", 64'(div_en_o), 64'h1);
      chk("single_tag", 64'(div_tag_o), 64'h0);
      chk("single_opa", 64'(div_op_a_o), 64'h4040_0000);
      chk("single_opb", 64'(div_op_b_o), 64'h3F80_0000);
      chk("single_rnd", 64'(div_rnd_o), 64'h1);
      step();
      req_i = '0;
      begin
         div_resp_t e;
         e.tag = 2'd0; e.res = 32'h4040_0000; e.status = 5'd0;
         exp_q.push_back(e);
      end
      div_valid_i = 1'b1; div_tag_i = 2'd0; div_res_i = 32'h4040_0000; div_status_i = 5'd0;
      #1;
`ifdef FP_DIV_DISP_BYPASS_EN
      chk("lat_same_cycle", 64'(resp_valid_o), 64'h1);
`else
      chk("lat_same_cycle", 64'(resp_valid_o), 64'h0);
`endif
      step();
      div_valid_i = 1'b0;
`ifdef FP_DIV_DISP_BYPASS_EN
      chk("lat_next_cycle", 64'(resp_valid_o), 64'h0);
`else
      chk("lat_next_cycle", 64'(resp_valid_o), 64'h1);
`endif
      step();

      // round-robin from a fresh pointer
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, 32'h3F80_0000 + 32'(i), 32'h4000_0000 + 32'(i), 3'(i));
      for (int k = 0; k < 5; k++) begin
         req_i = 4'b1111;
         #1;
         chk("rr_gnt", 64'(gnt_o), 64'(4'b0001 << rr_ord[k]));
         chk("rr_tag", 64'(div_tag_o), 64'(rr_ord[k]));
         chk("rr_opa", 64'(div_op_a_o), 64'(32'h3F80_0000 + 32'(rr_ord[k])));
         step();
         req_i = '0;
         div_ret(rr_ord[k], 32'h4100_0000 + 32'(k), 5'(k), 1'b1);
         step();
      end

      // credit stall
      resp_ready_i = '0;
      req_i = 4'b0001;
      #1;
      chk("cs_gnt0", 64'(gnt_o), 64'h1);
      step();
      req_i = 4'b0010;
      #1;
      chk("cs_gnt1", 64'(gnt_o), 64'h2);
      step();
      req_i = '0;
      div_ret(2'd0, 32'h4200_0000, 5'd1, 1'b1);
      div_ret(2'd1, 32'h4200_0001, 5'd2, 1'b1);
      req_i = 4'b0100;
      #1;
      chk("cs_stall_gnt", 64'(gnt_o), 64'h0);
      chk("cs_stall_en", 64'(div_en_o), 64'h0);
      step();
      chk("cs_stall_gnt2", 64'(gnt_o), 64'h0);
      resp_ready_i = 4'b0001;
      #1;
      chk("cs_pop_cycle_gnt", 64'(gnt_o), 64'h0);
      step();
      resp_ready_i = '0;
      #1;
      chk("cs_after_pop_gnt", 64'(gnt_o), 64'h4);
      step();
      req_i = '0;
      chk("cs_head_valid", 64'(resp_valid_o), 64'h2);

      // full FIFO: simultaneous push/pop, then overflow drop
      div_ret(2'd2, 32'h4200_0002, 5'd3, 1'b1);
      chk("full_head_valid", 64'(resp_valid_o), 64'h2);
      resp_ready_i = 4'b0010;
      div_ret(2'd3, 32'h4200_0003, 5'd4, 1'b1);
      resp_ready_i = '0;
      #1;
      chk("pushpop_err", 64'(err_o), 64'h0);
      chk("pushpop_head_valid", 64'(resp_valid_o), 64'h4);
      chk("pushpop_head_res", 64'(resp_res_o), 64'h4200_0002);
      div_ret(2'd0, 32'hDEAD_BEEF, 5'd0, 1'b0);
      chk("overflow_err", 64'(err_o), 64'h1);
      chk("overflow_head_valid", 64'(resp_valid_o), 64'h4);
      chk("overflow_head_res", 64'(resp_res_o), 64'h4200_0002);

      // reset with results buffered
      rst_ni = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_valid", 64'(resp_valid_o), 64'h0);
      chk("midrst_err", 64'(err_o), 64'h0);
      chk("midrst_gnt", 64'(gnt_o), 64'h0);
      step();
      rst_ni = 1'b1;
      req_i = 4'b0001;
      #1;
      chk("postrst_gnt", 64'(gnt_o), 64'h1);
      step();
      req_i = '0;
      resp_ready_i = '1;
      div_ret(2'd0, 32'h4300_0000, 5'd6, 1'b1);
      step();
      step();
      chk("postrst_err", 64'(err_o), 64'h0);

      // spurious result with nothing in flight
      div_ret(2'd1, 32'hBAD0_0001, 5'd7, 1'b0);
      chk("spur_err", 64'(err_o), 64'h1);
      chk("spur_valid", 64'(resp_valid_o), 64'h0);
      step();
      step();
      step();
      chk("spur_err_sticky", 64'(err_o), 64'h1);
      chk("spur_valid_hold", 64'(resp_valid_o), 64'h0);

      chk("scoreboard_drain", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
